// File: rtl/engine_read_write_controller_pkg.sv
// Shared packet, address and configuration types for the engine read/write
// controller and the kernel it drives.
package engine_read_write_controller_pkg;

  typedef enum logic [1:0] {
    SEQUENCE_INVALID = 2'd0,
    SEQUENCE_START   = 2'd1,
    SEQUENCE_VALID   = 2'd2,
    SEQUENCE_END     = 2'd3
  } FieldState;

  localparam int NUM_FIELDS = 2;

  typedef struct packed {
    FieldState   field_state;
    logic [31:0] value;
  } EnginePacketField;

  typedef struct packed {
    EnginePacketField [NUM_FIELDS-1:0] fields;
  } EnginePacketData;

  typedef struct packed {
    logic [31:0] base_address;
    logic [31:0] stride;
    logic [7:0]  engine_id;
    logic        write_enable;
  } ReadWriteConfigurationParameters;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  engine_id;
    logic        write_enable;
  } PacketRequestDataAddress;

endpackage

// File: rtl/engine_read_write_controller.sv
// Feeds a fixed-latency kernel from an upstream packet stream and buffers the
// kernel's address/result pairs into a credit-protected request FIFO.
module engine_read_write_controller
  import engine_read_write_controller_pkg::*;
#(
  parameter int KERNEL_LATENCY = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            config_valid_in,
  input  ReadWriteConfigurationParameters config_params_in,
  output logic                            config_ready_out,
  input  logic [31:0]                     packet_count_in,
  input  logic                            data_in_valid,
  input  EnginePacketData                 data_in,
  output logic                            data_in_ready,
  output ReadWriteConfigurationParameters kernel_config_out,
  output EnginePacketData                 kernel_data_out,
  input  PacketRequestDataAddress         kernel_address_in,
  input  EnginePacketData                 kernel_result_in,
  output logic                            req_valid_out,
  output PacketRequestDataAddress         req_address_out,
  output EnginePacketData                 req_data_out,
  input  logic                            req_ready_in,
  output logic                            busy_out,
  output logic                            done_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, BUSY, DRAIN, DONE} state_t;

  state_t                          state, state_next;
  ReadWriteConfigurationParameters cfg_q;
  logic [31:0]                     packet_count_q;
  logic [31:0]                     issued_count;
  logic [KERNEL_LATENCY-1:0]       tags;
  logic [CNT_W-1:0]                inflight, inflight_next;
  logic [CNT_W-1:0]                fifo_count, fifo_count_next;
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [CNT_W:0]                  credit_used;
  logic                            accept, retire, pop;

  PacketRequestDataAddress addr_mem [FIFO_DEPTH];
  EnginePacketData         data_mem [FIFO_DEPTH];

  // Every issued beat already owns a FIFO slot, so a retiring result can never
  // find the buffer full.
  assign credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
  assign data_in_ready = (state == BUSY) && (issued_count < packet_count_q) &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign accept        = data_in_valid && data_in_ready;
  assign retire        = tags[KERNEL_LATENCY-1];
  assign req_valid_out = (fifo_count != '0);
  assign pop           = req_valid_out && req_ready_in;

  assign inflight_next   = inflight + CNT_W'(accept) - CNT_W'(retire);
  assign fifo_count_next = fifo_count + CNT_W'(retire) - CNT_W'(pop);

  assign req_address_out   = addr_mem[rd_ptr];
  assign req_data_out      = data_mem[rd_ptr];
  assign kernel_data_out   = accept ? data_in : EnginePacketData'('0);
  assign kernel_config_out = (state == IDLE) ? ReadWriteConfigurationParameters'('0) : cfg_q;
  assign config_ready_out  = (state == IDLE);
  assign busy_out          = state inside {SETUP, BUSY, DRAIN};
  assign done_out          = (state == DONE);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (config_valid_in) state_next = SETUP;
      SETUP:   state_next = (packet_count_q == '0) ? DONE : BUSY;
      BUSY:    if (issued_count == packet_count_q) state_next = DRAIN;
      // Looking at post-update counts lets done follow the last pop directly.
      DRAIN:   if (inflight_next == '0 && fifo_count_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state          <= IDLE;
      cfg_q          <= '0;
      packet_count_q <= '0;
      issued_count   <= '0;
      tags           <= '0;
      inflight       <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      state      <= state_next;
      tags       <= (tags << 1) | KERNEL_LATENCY'(accept);
      inflight   <= inflight_next;
      fifo_count <= fifo_count_next;
      if (state == IDLE && config_valid_in) begin
        cfg_q          <= config_params_in;
        packet_count_q <= packet_count_in;
        issued_count   <= '0;
      end else if (accept) begin
        issued_count <= issued_count + 32'd1;
      end
      if (retire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; fifo_count and the
  // pointers decide which entries are meaningful.
  always_ff @(posedge ap_clk) begin
    if (retire) begin
      addr_mem[wr_ptr] <= kernel_address_in;
      data_mem[wr_ptr] <= kernel_result_in;
    end
  end

endmodule

// File: tb/tb_engine_read_write_controller.sv
// Self-checking bench: a kernel model feeds the DUT, a scoreboard predicts each
// memory request from accepted beats, and a table drives whole transactions.
module tb_engine_read_write_controller;
  import engine_read_write_controller_pkg::*;

  localparam int KL = 3;
  localparam int FD = 8;

  logic                            ap_clk = 1'b0;
  logic                            ap_rst_n = 1'b0;
  logic                            config_valid_in = 1'b0;
  ReadWriteConfigurationParameters config_params_in = '0;
  logic                            config_ready_out;
  logic [31:0]                     packet_count_in = '0;
  logic                            data_in_valid = 1'b0;
  EnginePacketData                 data_in = '0;
  logic                            data_in_ready;
  ReadWriteConfigurationParameters kernel_config_out;
  EnginePacketData                 kernel_data_out;
  PacketRequestDataAddress         kernel_address_in;
  EnginePacketData                 kernel_result_in;
  logic                            req_valid_out;
  PacketRequestDataAddress         req_address_out;
  EnginePacketData                 req_data_out;
  logic                            req_ready_in = 1'b0;
  logic                            busy_out;
  logic                            done_out;

  engine_read_write_controller #(.KERNEL_LATENCY(KL), .FIFO_DEPTH(FD)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .config_valid_in(config_valid_in), .config_params_in(config_params_in),
    .config_ready_out(config_ready_out), .packet_count_in(packet_count_in),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_in_ready(data_in_ready),
    .kernel_config_out(kernel_config_out), .kernel_data_out(kernel_data_out),
    .kernel_address_in(kernel_address_in), .kernel_result_in(kernel_result_in),
    .req_valid_out(req_valid_out), .req_address_out(req_address_out),
    .req_data_out(req_data_out), .req_ready_in(req_ready_in),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Kernel model: address and result derived from the packet and configuration.
  function automatic PacketRequestDataAddress k_addr(input ReadWriteConfigurationParameters c,
                                                     input EnginePacketData p);
    PacketRequestDataAddress r;
    r.address      = c.base_address + p.fields[0].value * c.stride;
    r.engine_id    = c.engine_id[3:0];
    r.write_enable = c.write_enable;
    return r;
  endfunction

  function automatic EnginePacketData k_result(input ReadWriteConfigurationParameters c,
                                               input EnginePacketData p);
    EnginePacketData r;
    r = p;
    for (int i = 0; i < NUM_FIELDS; i++) r.fields[i].value = p.fields[i].value ^ c.stride;
    return r;
  endfunction

  function automatic EnginePacketData mk_pkt(input int unsigned s);
    EnginePacketData p;
    p.fields[0].field_state = SEQUENCE_START;
    p.fields[0].value       = s;
    p.fields[1].field_state = SEQUENCE_VALID;
    p.fields[1].value       = $urandom;
    return p;
  endfunction

  function automatic ReadWriteConfigurationParameters mk_cfg(input int i);
    ReadWriteConfigurationParameters c;
    c.base_address = 32'h1000_0000 + 32'(i) * 32'h100;
    c.stride       = 32'h11 * 32'(i + 1);
    c.engine_id    = 8'(i + 1);
    c.write_enable = i[0];
    return c;
  endfunction

  EnginePacketData kpipe [KL];
  always @(posedge ap_clk) begin
    kpipe[0] <= kernel_data_out;
    for (int i = 1; i < KL; i++) kpipe[i] <= kpipe[i-1];
  end
  assign kernel_address_in = k_addr(kernel_config_out, kpipe[KL-1]);
  assign kernel_result_in  = k_result(kernel_config_out, kpipe[KL-1]);

  typedef struct packed {
    PacketRequestDataAddress a;
    EnginePacketData         d;
  } exp_t;
  exp_t sb[$];

  ReadWriteConfigurationParameters cur_cfg = '0;
  int cyc = 0;
  int accepts, reqs, dones, busy_cycles;
  int first_acc_cyc, first_req_cyc, last_pop_cyc, done_cyc;
  bit stall_prev = 1'b0;
  exp_t stall_val;
  exp_t popped;

  always @(posedge ap_clk) cyc++;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("req_stable_valid", 128'(req_valid_out), 128'(1));
        check("req_stable_payload", 128'({req_address_out, req_data_out}), 128'(stall_val));
      end
      if (req_valid_out && first_req_cyc < 0) first_req_cyc = cyc;
      if (req_valid_out && req_ready_in) begin
        reqs++;
        last_pop_cyc = cyc;
        check("sb_nonempty_on_pop", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          popped = sb.pop_front();
          check("req_address", 128'(req_address_out), 128'(popped.a));
          check("req_data", 128'(req_data_out), 128'(popped.d));
        end
      end
      stall_prev = req_valid_out && !req_ready_in;
      stall_val  = {req_address_out, req_data_out};
      if (data_in_valid && data_in_ready) begin
        sb.push_back({k_addr(cur_cfg, data_in), k_result(cur_cfg, data_in)});
        accepts++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (done_out) begin
        dones++;
        done_cyc = cyc;
      end
      if (busy_out) busy_cycles++;
    end
  end

  bit          src_en = 1'b0;
  int unsigned valid_pct = 0;
  int unsigned ready_pct = 0;
  int unsigned seq = 0;

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      data_in_valid = src_en && ($urandom_range(99) < valid_pct);
      data_in       = mk_pkt(seq);
      seq++;
      req_ready_in  = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_config_ready"}, 128'(config_ready_out), 128'(1));
    check({tag, "_data_in_ready"}, 128'(data_in_ready), 128'(0));
    check({tag, "_req_valid"}, 128'(req_valid_out), 128'(0));
    check({tag, "_busy"}, 128'(busy_out), 128'(0));
    check({tag, "_done"}, 128'(done_out), 128'(0));
    check({tag, "_kernel_data"}, 128'(kernel_data_out), 128'(0));
    check({tag, "_kernel_config"}, 128'(kernel_config_out), 128'(0));
  endtask

  task automatic clear_stats();
    accepts = 0; reqs = 0; dones = 0; busy_cycles = 0;
    first_acc_cyc = -1; first_req_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_txn(input string tag, input ReadWriteConfigurationParameters c,
                           input logic [31:0] cnt);
    for (int i = 0; i < 200; i++) begin
      @(posedge ap_clk);
      #2;
      if (config_ready_out) break;
    end
    check({tag, "_idle_before_config"}, 128'(config_ready_out), 128'(1));
    clear_stats();
    cur_cfg          = c;
    config_params_in = c;
    packet_count_in  = cnt;
    config_valid_in  = 1'b1;
    @(posedge ap_clk);
    #2;
    config_valid_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && dones == 0; i++) begin
      @(negedge ap_clk);
      #2;
    end
    check({tag, "_done_seen"}, 128'(dones > 0), 128'(1));
    repeat (4) @(negedge ap_clk);
    #2;
  endtask

  typedef struct {
    logic [31:0] cnt;
    int unsigned vpct;
    int unsigned rpct;
    bit          chk_lat;
    int          exp_busy;
  } vec_t;
  vec_t vecs [4];

  initial begin
    vecs[0] = '{cnt: 32'd4,   vpct: 100, rpct: 100, chk_lat: 1'b1, exp_busy: -1};
    vecs[1] = '{cnt: 32'd0,   vpct: 100, rpct: 100, chk_lat: 1'b0, exp_busy: 1};
    vecs[2] = '{cnt: 32'd100, vpct: 60,  rpct: 50,  chk_lat: 1'b0, exp_busy: -1};
    vecs[3] = '{cnt: 32'd7,   vpct: 100, rpct: 30,  chk_lat: 1'b0, exp_busy: -1};
    clear_stats();

    #2;
    reset_checks("reset_initial");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    src_en   = 1'b1;

    foreach (vecs[v]) begin
      string tag;
      tag       = $sformatf("vec%0d", v);
      valid_pct = vecs[v].vpct;
      ready_pct = vecs[v].rpct;
      start_txn(tag, mk_cfg(v), vecs[v].cnt);
      wait_done(tag, 3000);
      check({tag, "_requests"}, 128'(reqs), 128'(vecs[v].cnt));
      check({tag, "_done_pulses"}, 128'(dones), 128'(1));
      check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
      if (vecs[v].cnt != 0)
        check({tag, "_done_after_last_pop"}, 128'(done_cyc - last_pop_cyc), 128'(1));
      if (vecs[v].chk_lat)
        check({tag, "_first_req_latency"}, 128'(first_req_cyc - first_acc_cyc), 128'(KL + 1));
      if (vecs[v].exp_busy >= 0)
        check({tag, "_busy_cycles"}, 128'(busy_cycles), 128'(vecs[v].exp_busy));
    end

    // Backpressure: the credit rule must stop intake with the FIFO exactly full.
    valid_pct = 100;
    ready_pct = 0;
    start_txn("bp", mk_cfg(5), 32'd20);
    repeat (30) @(negedge ap_clk);
    #2;
    check("bp_accepts_before_stall", 128'(accepts), 128'(FD));
    check("bp_data_in_ready_low", 128'(data_in_ready), 128'(0));
    check("bp_fifo_count_full", 128'(dut.fifo_count), 128'(FD));
    check("bp_no_pops", 128'(reqs), 128'(0));
    ready_pct = 100;
    wait_done("bp", 500);
    check("bp_requests", 128'(reqs), 128'(20));
    check("bp_sb_empty", 128'(sb.size()), 128'(0));

    // Reset mid-transaction: everything returns to reset values and no stale
    // request may surface afterwards.
    valid_pct = 100;
    ready_pct = 100;
    start_txn("rst", mk_cfg(6), 32'd10);
    for (int i = 0; i < 40 && accepts < 3; i++) begin
      @(negedge ap_clk);
      #2;
    end
    check("rst_accepts_before_abort", 128'(accepts), 128'(3));
    ap_rst_n = 1'b0;
    #1;
    reset_checks("reset_mid_busy");
    sb.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    reqs = 0;
    first_req_cyc = -1;
    repeat (25) @(negedge ap_clk);
    #2;
    check("rst_no_stale_requests", 128'(reqs), 128'(0));
    check("rst_no_stale_valid", 128'(first_req_cyc), 128'(-1));
    start_txn("post_rst", mk_cfg(7), 32'd3);
    wait_done("post_rst", 500);
    check("post_rst_requests", 128'(reqs), 128'(3));
    check("post_rst_sb_empty", 128'(sb.size()), 128'(0));

    // Configuration offered while busy must be ignored.
    valid_pct = 100;
    ready_pct = 50;
    start_txn("cfg_busy", mk_cfg(8), 32'd6);
    repeat (2) @(posedge ap_clk);
    #2;
    config_params_in = mk_cfg(9);
    packet_count_in  = 32'd99;
    config_valid_in  = 1'b1;
    check("cfg_busy_ready_low", 128'(config_ready_out), 128'(0));
    @(posedge ap_clk);
    #2;
    config_valid_in = 1'b0;
    check("cfg_busy_kernel_config", 128'(kernel_config_out), 128'(mk_cfg(8)));
    check("cfg_busy_packet_count", 128'(dut.packet_count_q), 128'(6));
    wait_done("cfg_busy", 500);
    check("cfg_busy_requests", 128'(reqs), 128'(6));
    check("cfg_busy_sb_empty", 128'(sb.size()), 128'(0));

    src_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
